pcie_reg_bank: RTL

PCIE_REG_BANK -- requirements
Module: pcie_reg_bank

---
 rtl/pcie_reg_bank_if.sv | 33 +++
 rtl/pcie_reg_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pcie_reg_bank_if.sv
// pcie_reg_bank_if
// CPU-side register access bus for pcie_reg_bank. Signal suffixes are named
// from the register bank's point of view.
//   cpuChan_in     : channel of the current read or write
//   cpuWrData_in   : write data
//   cpuWrValid_in  : write offered
//   cpuWrReady_out : write accepted (bank idle)
//   cpuRdReady_in  : read requested / response consumable
//   cpuRdData_out  : registered read data
//   cpuRdValid_out : read data valid
// master = CPU side, slave = register bank.
interface pcie_reg_bank_if #(
  parameter int CHAN_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic [CHAN_WIDTH-1:0] cpuChan_in;
  logic [DATA_WIDTH-1:0] cpuWrData_in;
  logic                  cpuWrValid_in;
  logic                  cpuWrReady_out;
  logic                  cpuRdReady_in;
  logic [DATA_WIDTH-1:0] cpuRdData_out;
  logic                  cpuRdValid_out;

  modport master (
    output cpuChan_in, cpuWrData_in, cpuWrValid_in, cpuRdReady_in,
    input  cpuWrReady_out, cpuRdData_out, cpuRdValid_out
  );

  modport slave (
    input  cpuChan_in, cpuWrData_in, cpuWrValid_in, cpuRdReady_in,
    output cpuWrReady_out, cpuRdData_out, cpuRdValid_out
  );
endinterface

// File: rtl/pcie_reg_bank.sv
// pcie_reg_bank
// Channel-addressed register bank: NUM_REGS local read/write registers,
// NUM_EXT 64-bit external read sources (LSW/MSW channel pairs with a shadow
// so the MSW returns the same snapshot as the preceding LSW), and error /
// timeout counters for unmapped accesses and stalled external sources.
// Ports:
//   pcieClk_in    : clock
//   pcieResetN_in : asynchronous active-low reset
//   cpu           : CPU bus (pcie_reg_bank_if.slave)
//   regs_out      : local register values, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wrStrobe_out  : one-cycle pulse per written local register
//   extData_in    : external source data, source k at [k*64 +: 64]
//   extValid_in   : external source data valid
//   errCount_out  : unmapped access count (saturating)
//   toCount_out   : external timeout count (saturating)
module pcie_reg_bank #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CHAN_WIDTH = 7,
  parameter int NUM_EXT    = 2,
  parameter int EXT_BASE   = 64,
  parameter int TIMEOUT    = 255,
  parameter bit EN_SWAP    = 1'b0
) (
  input  logic                           pcieClk_in,
  input  logic                           pcieResetN_in,
  pcie_reg_bank_if.slave                 cpu,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            wrStrobe_out,
  input  logic [NUM_EXT*64-1:0]          extData_in,
  input  logic [NUM_EXT-1:0]             extValid_in,
  output logic [15:0]                    errCount_out,
  output logic [15:0]                    toCount_out
);

  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int EXT_IDX_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
  localparam int HALF      = DATA_WIDTH / 2;
  localparam logic [DATA_WIDTH-1:0] UNMAPPED_DATA = DATA_WIDTH'(32'hDEAD_BEEF);
  localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA  = DATA_WIDTH'(32'hFFFF_FFFF);

  if (NUM_REGS > EXT_BASE) begin : gOverlapCheck
    $error("pcie_reg_bank: local and external channel ranges overlap");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : gTimeoutCheck
    $error("pcie_reg_bank: TIMEOUT must be within 1..65535");
  end

  typedef enum logic [1:0] {IDLE, RESP, EXT_WAIT, HOLD} state_t;

  state_t                state_reg;
  logic                  wrReady_reg;
  logic                  rdValid_reg;
  logic [DATA_WIDTH-1:0] rdData_reg;
  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [63:0]           shadow_reg [NUM_EXT];
  logic [NUM_EXT-1:0]    shadowValid_reg;
  logic [NUM_REGS-1:0]   wrStrobe_reg;
  logic [15:0]           errCount_reg;
  logic [15:0]           toCount_reg;
  logic [15:0]           waitCnt_reg;
  logic [EXT_IDX_W-1:0]  extIdx_reg;
  logic                  extMsw_reg;

  // Channel decode of the live bus channel
  logic                  isLocal;
  logic                  isExt;
  logic                  chanMsw;
  logic [CHAN_WIDTH-1:0] chanOff;
  logic [REG_IDX_W-1:0]  regIdx;
  logic [EXT_IDX_W-1:0]  extIdx;
  logic [63:0]           extWord;

  always_comb begin
    chanOff = cpu.cpuChan_in - CHAN_WIDTH'(EXT_BASE);
    isLocal = int'(cpu.cpuChan_in) < NUM_REGS;
    isExt   = (int'(cpu.cpuChan_in) >= EXT_BASE) &&
              (int'(cpu.cpuChan_in) < EXT_BASE + 2 * NUM_EXT);
    extIdx  = EXT_IDX_W'(chanOff >> 1);
    chanMsw = chanOff[0];
    regIdx  = REG_IDX_W'(cpu.cpuChan_in);
  end

  assign extWord = extData_in[int'(extIdx_reg) * 64 +: 64];

  // Halfword swap is applied at the read-data register only; stored
  // registers and shadows always hold the unswapped value.
  function automatic logic [DATA_WIDTH-1:0] rdFmt(input logic [DATA_WIDTH-1:0] d);
    if (EN_SWAP) return {d[HALF-1:0], d[DATA_WIDTH-1:HALF]};
    return d;
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge pcieClk_in or negedge pcieResetN_in) begin
    if (!pcieResetN_in) begin
      state_reg       <= IDLE;
      wrReady_reg     <= 1'b0;
      rdValid_reg     <= 1'b0;
      rdData_reg      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
      for (int i = 0; i < NUM_EXT; i++) shadow_reg[i] <= '0;
      shadowValid_reg <= '0;
      wrStrobe_reg    <= '0;
      errCount_reg    <= '0;
      toCount_reg     <= '0;
      waitCnt_reg     <= '0;
      extIdx_reg      <= '0;
      extMsw_reg      <= 1'b0;
    end else begin
      wrStrobe_reg <= '0;
      case (state_reg)
        IDLE: begin
          // The first edge after reset only raises ready; nothing is
          // accepted while ready is still low.
          wrReady_reg <= 1'b1;
          if (wrReady_reg && cpu.cpuWrValid_in) begin
            // Write wins over a simultaneous read; the read retries later.
            if (isLocal) begin
              regs_reg[regIdx]     <= cpu.cpuWrData_in;
              wrStrobe_reg[regIdx] <= 1'b1;
            end else if (!isExt) begin
              errCount_reg <= satInc(errCount_reg);
            end
          end else if (wrReady_reg && cpu.cpuRdReady_in) begin
            wrReady_reg <= 1'b0;
            if (isLocal) begin
              rdData_reg  <= rdFmt(regs_reg[regIdx]);
              rdValid_reg <= 1'b1;
              state_reg   <= RESP;
            end else if (isExt) begin
              extIdx_reg <= extIdx;
              extMsw_reg <= chanMsw;
              if (chanMsw && shadowValid_reg[extIdx]) begin
                // MSW of a snapshot already taken by the LSW read
                rdData_reg              <= rdFmt(DATA_WIDTH'(shadow_reg[extIdx][63:32]));
                shadowValid_reg[extIdx] <= 1'b0;
                rdValid_reg             <= 1'b1;
                state_reg               <= RESP;
              end else begin
                waitCnt_reg <= 16'(TIMEOUT);
                state_reg   <= EXT_WAIT;
              end
            end else begin
              rdData_reg   <= rdFmt(UNMAPPED_DATA);
              errCount_reg <= satInc(errCount_reg);
              rdValid_reg  <= 1'b1;
              state_reg    <= RESP;
            end
          end
        end
        EXT_WAIT: begin
          // Valid data takes priority over an expiring counter.
          if (extValid_in[extIdx_reg]) begin
            shadow_reg[extIdx_reg] <= extWord;
            rdData_reg <= rdFmt(extMsw_reg ? DATA_WIDTH'(extWord[63:32])
                                           : DATA_WIDTH'(extWord[31:0]));
            if (!extMsw_reg) shadowValid_reg[extIdx_reg] <= 1'b1;
            rdValid_reg <= 1'b1;
            state_reg   <= RESP;
          end else if (waitCnt_reg == 16'd0) begin
            rdData_reg  <= rdFmt(TIMEOUT_DATA);
            toCount_reg <= satInc(toCount_reg);
            rdValid_reg <= 1'b1;
            state_reg   <= RESP;
          end else begin
            waitCnt_reg <= waitCnt_reg - 16'd1;
          end
        end
        RESP, HOLD: begin
          if (cpu.cpuRdReady_in) begin
            rdValid_reg <= 1'b0;
            wrReady_reg <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            state_reg <= HOLD;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gRegsOut
    assign regs_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[gi];
  end

  assign cpu.cpuWrReady_out = wrReady_reg;
  assign cpu.cpuRdValid_out = rdValid_reg;
  assign cpu.cpuRdData_out  = rdData_reg;
  assign wrStrobe_out       = wrStrobe_reg;
  assign errCount_out       = errCount_reg;
  assign toCount_out        = toCount_reg;

endmodule
